jt9346_ctrl: RTL

Host-side serial master for the 93C46-compatible EEPROM. Accepts one parallel command at a time from the CPU/core side and serialises it onto the sclk/sdi/scs lines that feed the EEPROM model. For reads, it deserialises sdo into a 16-bit word. After each programming command it checks the ready/busy status, either by polling sdo or by a fixed wait.

---
 rtl/jt9346_ctrl_if.sv | 15 +
 rtl/jt9346_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/jt9346_ctrl_if.sv
// Host command bus of the 93C46 serial master: one parallel command at a
// time in, completion status and read word out.
interface jt9346_ctrl_if;
    logic        start;
    logic [2:0]  cmd;
    logic [5:0]  addr;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] dout;

    modport master (output start, cmd, addr, din, input busy, done, err, dout);
    modport slave  (input start, cmd, addr, din, output busy, done, err, dout);
endinterface

// File: rtl/jt9346_ctrl.sv
// jt9346_ctrl: host-side serial master for a 93C46-compatible EEPROM.
// It serialises one command frame onto sclk/sdi/scs and deserialises READ
// data from sdo. Programming commands finish with a ready check.
// Build option JT9346_CTRL_POLL_EN: when defined, ready is polled on sdo
// with a POLL_MAX timeout. When undefined, a fixed WAIT_CYC wait with scs low
// is used instead.
module jt9346_ctrl #(
    parameter int CLKDIV   = 4,
    parameter int TCS      = 2,
    parameter int POLL_MAX = 1023,
    parameter int WAIT_CYC = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    jt9346_ctrl_if.slave    host,
    output logic            sclk,
    output logic            sdi,
    output logic            scs,
    input  logic            sdo
);
    localparam logic [2:0] CMD_READ  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_ERASE = 3'd2;
    localparam logic [2:0] CMD_EWEN  = 3'd3;
    localparam logic [2:0] CMD_EWDS  = 3'd4;
    localparam logic [2:0] CMD_ERAL  = 3'd5;
    localparam logic [2:0] CMD_WRAL  = 3'd6;
    localparam logic [2:0] CMD_ILL   = 3'd7;

    // One shared counter covers slot phase, deselect time and the ready wait.
    // It is sized for the largest of them, so both builds fit.
    localparam int M1      = (2 * CLKDIV > TCS) ? 2 * CLKDIV : TCS;
    localparam int M2      = (POLL_MAX > WAIT_CYC) ? POLL_MAX : WAIT_CYC;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLKDIV - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(2 * CLKDIV - 1);
    localparam logic [CNT_W-1:0] TCS_LAST  = CNT_W'(TCS - 1);
`ifdef JT9346_CTRL_POLL_EN
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX - 1);
`else
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
`endif

    typedef enum logic [2:0] {IDLE, SETUP, HDR, TXD, RXD, DESEL, POLL, FIN} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [4:0]        bit_cnt_reg;
    logic [2:0]        cmd_reg;
    logic [24:0]       tx_reg;
    logic [14:0]       rx_reg;
    logic [15:0]       dout_reg;
    logic              err_reg;
    logic              sdo_meta_reg, sdo_sync_reg;

    logic accept, in_slot, slot_end, needs_ready;

    assign accept      = (state_reg == IDLE) && host.start;
    assign in_slot     = (state_reg == HDR) || (state_reg == TXD) || (state_reg == RXD);
    assign slot_end    = in_slot && (cnt_reg == SLOT_LAST);
    assign needs_ready = (cmd_reg == CMD_WRITE) || (cmd_reg == CMD_ERASE) ||
                         (cmd_reg == CMD_ERAL)  || (cmd_reg == CMD_WRAL);

    // Start bit, opcode and address field; the 00-opcode commands carry
    // their sub-opcode in the top two address bits.
    function automatic logic [8:0] frame_hdr(input logic [2:0] c, input logic [5:0] a);
        case (c)
            CMD_READ:  frame_hdr = {3'b110, a};
            CMD_WRITE: frame_hdr = {3'b101, a};
            CMD_ERASE: frame_hdr = {3'b111, a};
            CMD_EWEN:  frame_hdr = 9'b100_110000;
            CMD_ERAL:  frame_hdr = 9'b100_100000;
            CMD_WRAL:  frame_hdr = 9'b100_010000;
            default:   frame_hdr = 9'b100_000000;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: frame sequencing and the ready check.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (host.start) state_next = (host.cmd == CMD_ILL) ? FIN : SETUP;
            SETUP: if (cnt_reg == DIV_LAST) state_next = HDR;
            HDR:   if (slot_end && bit_cnt_reg == 5'd8) begin
                       if (cmd_reg == CMD_READ)
                           state_next = RXD;
                       else if (cmd_reg == CMD_WRITE || cmd_reg == CMD_WRAL)
                           state_next = TXD;
                       else
                           state_next = DESEL;
                   end
            TXD,
            RXD:   if (slot_end && bit_cnt_reg == 5'd15) state_next = DESEL;
            DESEL: if (cnt_reg == TCS_LAST) state_next = needs_ready ? POLL : FIN;
`ifdef JT9346_CTRL_POLL_EN
            POLL:  if (sdo_sync_reg || cnt_reg == POLL_LAST) state_next = FIN;
`else
            POLL:  if (cnt_reg == WAIT_LAST) state_next = FIN;
`endif
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: sdo synchroniser, counters, shift registers and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdo_meta_reg <= 1'b0;
            sdo_sync_reg <= 1'b0;
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            cmd_reg      <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            dout_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            sdo_meta_reg <= sdo;
            sdo_sync_reg <= sdo_meta_reg;

            if (state_reg == IDLE || state_next != state_reg || slot_end)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + CNT_W'(1);

            if (state_next != state_reg)
                bit_cnt_reg <= '0;
            else if (slot_end)
                bit_cnt_reg <= bit_cnt_reg + 5'd1;

            if (accept) begin
                cmd_reg <= host.cmd;
                err_reg <= (host.cmd == CMD_ILL);
                tx_reg  <= {frame_hdr(host.cmd, host.addr),
                            (host.cmd == CMD_WRITE || host.cmd == CMD_WRAL) ? host.din : 16'h0000};
            end else if (slot_end && state_reg != RXD) begin
                tx_reg <= {tx_reg[23:0], 1'b0};
            end

            if (slot_end && state_reg == RXD) begin
                rx_reg <= {rx_reg[13:0], sdo_sync_reg};
                if (bit_cnt_reg == 5'd15)
                    dout_reg <= {rx_reg, sdo_sync_reg};
            end

`ifdef JT9346_CTRL_POLL_EN
            if (state_reg == POLL && !sdo_sync_reg && cnt_reg == POLL_LAST)
                err_reg <= 1'b1;
`endif
        end
    end

    // Outputs decoded from registered state, so a reset clears them at once.
    always_comb begin
        sclk = in_slot && (cnt_reg > DIV_LAST);
        sdi  = ((state_reg == HDR) || (state_reg == TXD)) && tx_reg[24];
`ifdef JT9346_CTRL_POLL_EN
        scs  = (state_reg == SETUP) || in_slot || (state_reg == POLL);
`else
        scs  = (state_reg == SETUP) || in_slot;
`endif
        host.busy = (state_reg != IDLE);
        host.done = (state_reg == FIN);
        host.err  = err_reg;
        host.dout = dout_reg;
    end
endmodule
